// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Time-multiplexing scan controller for a common-anode 7-segment array.
// A CPU-side writer offers a whole display image through a valid/ready
// handshake; the image is parked in pending registers and copied into the
// shadow (displayed) image only at a frame boundary, so a frame never
// shows a mix of old and new digits. Each digit slot starts with a dead
// time where all anodes are off to avoid ghosting.
//
// Ports
//   clk         system clock
//   rst_n       synchronous reset, active low
//   wr_valid    new display image offered
//   wr_ready    controller can accept an image (no pending image)
//   wr_data     hex nibbles, digit i = wr_data[4i+3:4i]
//   wr_point    decimal point per digit, 1 = lit
//   wr_blank    per-digit blank, 1 = dark
//   wr_lzb      leading-zero blanking enable
//   hex         nibble to the shared decoder
//   le          decoder blank, 1 = segments off
//   point       decoder point input, 1 = lit
//   an          digit anodes, active low
//   frame_done  one-cycle pulse after the last digit slot ends
module seg_scan_ctrl #(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 100000,
    parameter int DEAD_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [4*DIGITS-1:0]   wr_data,
    input  logic [DIGITS-1:0]     wr_point,
    input  logic [DIGITS-1:0]     wr_blank,
    input  logic                  wr_lzb,
    output logic [3:0]            hex,
    output logic                  le,
    output logic                  point,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(DIGITS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] DEAD_END   = PW'(DEAD_CYC);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    // Scan timing
    logic [PW-1:0]          r_presc;
    logic [IW-1:0]          r_idx;

    // Displayed image
    logic [4*DIGITS-1:0]    r_sh_data;
    logic [DIGITS-1:0]      r_sh_point;
    logic [DIGITS-1:0]      r_sh_blank;
    logic                   r_sh_lzb;

    // Accepted image waiting for the next frame boundary
    logic [4*DIGITS-1:0]    r_pd_data;
    logic [DIGITS-1:0]      r_pd_point;
    logic [DIGITS-1:0]      r_pd_blank;
    logic                   r_pd_lzb;
    logic                   r_pd_valid;

    // Registered outputs
    logic [3:0]             r_hex;
    logic                   r_le;
    logic                   r_point;
    logic [DIGITS-1:0]      r_an;
    logic                   r_frame_done;

    logic                   w_tick;
    logic                   w_frame_end;
    logic                   w_accept;
    logic [DIGITS-1:0]      w_lz;
    logic                   w_zero_above;
    logic                   w_dark;
    logic [3:0]             w_nib;

    assign w_tick      = (r_presc == PRESC_LAST);
    assign w_frame_end = w_tick && (r_idx == IDX_LAST);
    // Ready comes straight from state, so there is no wr_valid -> wr_ready path.
    assign wr_ready    = ~r_pd_valid;
    assign w_accept    = wr_valid && ~r_pd_valid;

    // Digit i>0 is a leading zero when it and every higher digit are zero.
    // NOTE: every always_comb output gets a default before any conditional
    // update, otherwise synthesis infers a latch.
    always_comb begin
        w_lz         = '0;
        w_zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_zero_above = w_zero_above && (r_sh_data[4*i +: 4] == 4'h0);
            w_lz[i]      = r_sh_lzb && w_zero_above;
        end
    end

    assign w_nib  = r_sh_data[4*r_idx +: 4];
    assign w_dark = r_sh_blank[r_idx] | w_lz[r_idx];

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_sh_data    <= '0;
            r_sh_point   <= '0;
            r_sh_blank   <= '1;
            r_sh_lzb     <= 1'b0;
            r_pd_data    <= '0;
            r_pd_point   <= '0;
            r_pd_blank   <= '0;
            r_pd_lzb     <= 1'b0;
            r_pd_valid   <= 1'b0;
            r_hex        <= 4'h0;
            r_le         <= 1'b1;
            r_point      <= 1'b0;
            r_an         <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end

            // Accept and commit are mutually exclusive: accept needs an
            // empty pending slot, commit needs a full one.
            if (w_accept) begin
                r_pd_data  <= wr_data;
                r_pd_point <= wr_point;
                r_pd_blank <= wr_blank;
                r_pd_lzb   <= wr_lzb;
                r_pd_valid <= 1'b1;
            end else if (w_frame_end && r_pd_valid) begin
                r_sh_data  <= r_pd_data;
                r_sh_point <= r_pd_point;
                r_sh_blank <= r_pd_blank;
                r_sh_lzb   <= r_pd_lzb;
                r_pd_valid <= 1'b0;
            end

            // Outputs reflect the current slot one cycle late.
            r_an         <= (r_presc < DEAD_END) ? '1 : ~(DIGITS'(1) << r_idx);
            r_hex        <= w_nib;
            r_le         <= w_dark;
            r_point      <= r_sh_point[r_idx] & ~w_dark;
            r_frame_done <= w_frame_end;
        end
    end

    assign hex        = r_hex;
    assign le         = r_le;
    assign point      = r_point;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl
// Scoreboarded bench for seg_scan_ctrl with DIGITS=4, SCAN_DIV=4, DEAD_CYC=1.
// A reference model steps once per clock from elapsed-time arithmetic and
// pushes the expected output set into a queue; a monitor pops one entry per
// cycle on the falling edge and compares it with the DUT outputs.
module tb_seg_scan_ctrl;

    localparam int ND   = 4;
    localparam int SD   = 4;
    localparam int DEAD = 1;

    typedef struct packed {
        logic [ND-1:0] an;
        logic          le;
        logic          point;
        logic [3:0]    hex;
        logic          fd;
        logic          rdy;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic            wr_valid;
    logic            wr_ready;
    logic [4*ND-1:0] wr_data;
    logic [ND-1:0]   wr_point;
    logic [ND-1:0]   wr_blank;
    logic            wr_lzb;
    logic [3:0]      hex;
    logic            le;
    logic            point;
    logic [ND-1:0]   an;
    logic            frame_done;

    int n_cmp = 0;
    int n_err = 0;

    exp_t q[$];

    seg_scan_ctrl #(.DIGITS(ND), .SCAN_DIV(SD), .DEAD_CYC(DEAD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .wr_point   (wr_point),
        .wr_blank   (wr_blank),
        .wr_lzb     (wr_lzb),
        .hex        (hex),
        .le         (le),
        .point      (point),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Time since reset is a single counter; slot and phase are derived from it.
    // The display holds a "shown" image and at most one "queued" image.
    int              m_c;
    bit              m_started = 0;
    logic [4*ND-1:0] s_data, p_data;
    logic [ND-1:0]   s_point, p_point, s_blank, p_blank;
    logic            s_lzb, p_lzb;
    bit              m_pend;

    initial begin
        exp_t e;
        int slot, phase, hi;
        bit supp, dark, acc, com;
        logic [ND-1:0] onehot;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_started = 1;
                m_c = 0;
                s_data = '0; s_point = '0; s_blank = '1; s_lzb = 0;
                m_pend = 0;
                e = '{an: '1, le: 1'b1, point: 1'b0, hex: 4'h0, fd: 1'b0, rdy: 1'b1};
                q.push_back(e);
            end else if (m_started) begin
                slot  = (m_c / SD) % ND;
                phase = m_c % SD;
                // Highest digit holding a non-zero value; -1 if all zero.
                hi = -1;
                for (int i = 0; i < ND; i++)
                    if (s_data[4*i +: 4] != 4'h0) hi = i;
                supp = s_lzb && (slot > 0) && (slot > hi);
                dark = s_blank[slot] || supp;
                onehot = '0;
                onehot[slot] = 1'b1;
                e.an    = (phase < DEAD) ? '1 : ~onehot;
                e.hex   = s_data[4*slot +: 4];
                e.le    = dark;
                e.point = s_point[slot] && !dark;
                e.fd    = (phase == SD - 1) && (slot == ND - 1);
                acc = wr_valid && !m_pend;
                com = e.fd && m_pend;
                if (acc) begin
                    p_data = wr_data; p_point = wr_point; p_blank = wr_blank; p_lzb = wr_lzb;
                    m_pend = 1;
                end
                if (com) begin
                    s_data = p_data; s_point = p_point; s_blank = p_blank; s_lzb = p_lzb;
                    m_pend = 0;
                end
                e.rdy = !m_pend;
                m_c++;
                q.push_back(e);
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("an",         32'(an),         32'(e.an));
                check("le",         32'(le),         32'(e.le));
                check("point",      32'(point),      32'(e.point));
                check("hex",        32'(hex),        32'(e.hex));
                check("frame_done", 32'(frame_done), 32'(e.fd));
                check("wr_ready",   32'(wr_ready),   32'(e.rdy));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b, input logic l);
        int n;
        @(negedge clk);
        wr_valid = 1'b1; wr_data = d; wr_point = p; wr_blank = b; wr_lzb = l;
        n = 0;
        while (wr_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout at %0t: wr_ready stuck at %b, required 1", $time, wr_ready);
        end
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_frame_done();
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_cmp++; n_err++;
            $display("FAIL frame_done_timeout at %0t: frame_done stuck at %b, required 1", $time, frame_done);
        end
    endtask

    initial begin
        rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_point = '0; wr_blank = '0; wr_lzb = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(20);

        // Plain digits with one point, accepted mid-frame.
        send(16'h1234, 4'b0010, 4'b0000, 1'b0);
        idle(34);
        // Leading-zero blanking of the two upper digits.
        send(16'h0050, 4'b1111, 4'b0000, 1'b1);
        idle(34);
        // All zeros: only digit 0 stays lit.
        send(16'h0000, 4'b0000, 4'b0000, 1'b1);
        idle(34);
        // Same data with digit 0 blanked: everything dark.
        send(16'h0000, 4'b0000, 4'b0001, 1'b1);
        idle(34);

        // Valid held high with new data every cycle.
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            wr_valid = 1'b1;
            wr_data  = 16'($urandom);
            wr_point = 4'($urandom);
            wr_blank = 4'($urandom_range(0, 3));
            wr_lzb   = 1'($urandom);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        idle(34);

        // Reset pulse while an image is pending.
        wait_frame_done();
        send(16'h9ABC, 4'b1111, 4'b0000, 1'b0);
        idle(2);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(40);

        // Randomized images with random gaps.
        for (int k = 0; k < 20; k++) begin
            send(16'($urandom) & (($urandom_range(0, 1) != 0) ? 16'h00FF : 16'hFFFF),
                 4'($urandom), 4'($urandom_range(0, 15) & 4'($urandom)), 1'($urandom));
            idle($urandom_range(0, 40));
        end
        idle(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
